// File: rtl/t05_1602_lcd_seq.sv
// Command/data sequencer for a 1602 character LCD feeding an SPI byte transmitter.
// Runs the power-up init sequence, then expands write/clear requests into LCD bytes.
module t05_1602_lcd_seq #(
  parameter int unsigned POWERUP_CYCLES = 40000,
  parameter int unsigned CMD_CYCLES     = 400,
  parameter int unsigned CLEAR_CYCLES   = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_row,
  input  logic [3:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  output logic       init_done,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       spi_rs,
  input  logic       spi_busy,
  input  logic       spi_done
);

  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > CMD_CYCLES) ? POWERUP_CYCLES : CMD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > CLEAR_CYCLES) ? MAX_AB : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [7:0] BYTE_FUNC_SET  = 8'h38;
  localparam logic [7:0] BYTE_DISP_ON   = 8'h0C;
  localparam logic [7:0] BYTE_CLEAR     = 8'h01;
  localparam logic [7:0] BYTE_ENTRY_MOD = 8'h06;

  typedef enum logic [2:0] {
    PWR_WAIT,
    ISSUE,
    XFER,
    GAP,
    IDLE
  } state_t;

  typedef enum logic [2:0] {
    INIT0,
    INIT1,
    INIT2,
    INIT3,
    ADDR,
    CHAR,
    CLEAR
  } phase_t;

  state_t           state, state_nx;
  phase_t           phase, phase_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] gap_load;
  logic             row_q, row_nx;
  logic [3:0]       col_q, col_nx;
  logic [7:0]       char_q, char_nx;
  logic             init_done_nx;
  logic             wr_ready_nx;
  logic             spi_start_nx;
  logic [7:0]       issue_data;
  logic             issue_rs;

  // A clear command needs the long settle; every other byte uses the short one.
  assign gap_load = (!spi_rs && (spi_data == BYTE_CLEAR)) ? CNT_W'(CLEAR_CYCLES)
                                                          : CNT_W'(CMD_CYCLES);

  // Next-state, phase, counter and request-latch logic.
  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    cnt_nx       = cnt;
    row_nx       = row_q;
    col_nx       = col_q;
    char_nx      = char_q;
    init_done_nx = init_done;
    spi_start_nx = 1'b0;

    case (state)
      PWR_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_nx = ISSUE;
          phase_nx = INIT0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      ISSUE: begin
        if (!spi_busy) begin
          spi_start_nx = 1'b1;
          state_nx     = XFER;
        end
      end

      XFER: begin
        if (spi_done) begin
          state_nx = GAP;
          cnt_nx   = gap_load;
        end
      end

      GAP: begin
        // A loaded value of 0 or 1 both leave after a single cycle.
        if (cnt <= CNT_W'(1)) begin
          case (phase)
            INIT0: begin
              phase_nx = INIT1;
              state_nx = ISSUE;
            end
            INIT1: begin
              phase_nx = INIT2;
              state_nx = ISSUE;
            end
            INIT2: begin
              phase_nx = INIT3;
              state_nx = ISSUE;
            end
            INIT3: begin
              init_done_nx = 1'b1;
              state_nx     = IDLE;
            end
            ADDR: begin
              phase_nx = CHAR;
              state_nx = ISSUE;
            end
            default: state_nx = IDLE;
          endcase
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      IDLE: begin
        // Clear has priority; a concurrent write is dropped and must be re-presented.
        if (init_done) begin
          if (clr_req) begin
            phase_nx = CLEAR;
            state_nx = ISSUE;
          end else if (wr_valid) begin
            row_nx   = wr_row;
            col_nx   = wr_col;
            char_nx  = wr_char;
            phase_nx = ADDR;
            state_nx = ISSUE;
          end
        end
      end

      default: state_nx = PWR_WAIT;
    endcase

    wr_ready_nx = (state_nx == IDLE) && init_done_nx;
  end

  // Byte and register-select for the phase about to be issued.
  always_comb begin
    issue_data = 8'h00;
    issue_rs   = 1'b0;
    case (phase_nx)
      INIT0:   issue_data = BYTE_FUNC_SET;
      INIT1:   issue_data = BYTE_DISP_ON;
      INIT2:   issue_data = BYTE_CLEAR;
      INIT3:   issue_data = BYTE_ENTRY_MOD;
      ADDR:    issue_data = {1'b1, row_nx, 2'b00, col_nx};
      CHAR: begin
        issue_data = char_nx;
        issue_rs   = 1'b1;
      end
      CLEAR:   issue_data = BYTE_CLEAR;
      default: issue_data = 8'h00;
    endcase
  end

  // State and registered outputs; spi_data/spi_rs only change on entry to ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      phase     <= INIT0;
      cnt       <= CNT_W'(POWERUP_CYCLES);
      row_q     <= 1'b0;
      col_q     <= 4'h0;
      char_q    <= 8'h00;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
      spi_start <= 1'b0;
      spi_data  <= 8'h00;
      spi_rs    <= 1'b0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      cnt       <= cnt_nx;
      row_q     <= row_nx;
      col_q     <= col_nx;
      char_q    <= char_nx;
      init_done <= init_done_nx;
      wr_ready  <= wr_ready_nx;
      spi_start <= spi_start_nx;
      if (state_nx == ISSUE) begin
        spi_data <= issue_data;
        spi_rs   <= issue_rs;
      end
    end
  end

endmodule

// File: tb/tb_t05_1602_lcd_seq.sv
// Self-checking bench for t05_1602_lcd_seq: SPI responder model, start-pulse monitor,
// and per-scenario tasks checking bytes and timing against rules derived from the LCD protocol.
module tb_t05_1602_lcd_seq;

  localparam int P_PWR    = 8;
  localparam int P_CMD    = 2;
  localparam int P_CLR    = 5;
  localparam int SPI_LAT  = 12;
  localparam int DONE_OFS = SPI_LAT + 1;
  localparam int BUDGET   = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_row = 1'b0;
  logic [3:0] wr_col = 4'h0;
  logic [7:0] wr_char = 8'h00;
  logic       clr_req = 1'b0;
  logic       init_done;
  logic       spi_start;
  logic [7:0] spi_data;
  logic       spi_rs;
  logic       spi_busy;
  logic       spi_done;

  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic force_busy = 1'b0;
  logic spur_done = 1'b0;
  int   m_cnt = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic       r;
    int         c;
  } rec_t;

  rec_t st_q[$];

  assign spi_busy = m_busy | force_busy;
  assign spi_done = m_done | spur_done;

  t05_1602_lcd_seq #(
    .POWERUP_CYCLES(P_PWR),
    .CMD_CYCLES    (P_CMD),
    .CLEAR_CYCLES  (P_CLR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_char  (wr_char),
    .clr_req  (clr_req),
    .init_done(init_done),
    .spi_start(spi_start),
    .spi_data (spi_data),
    .spi_rs   (spi_rs),
    .spi_busy (spi_busy),
    .spi_done (spi_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI transmitter model: busy after start, done pulse SPI_LAT cycles after start.
  always @(negedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (spi_start) begin
        m_busy = 1'b1;
        m_cnt  = SPI_LAT;
      end
    end
  end

  // Record every start pulse with its byte and the cycle it was seen.
  always @(negedge clk) begin
    if (!rst && spi_start) st_q.push_back('{spi_data, spi_rs, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int gap_of(input logic [7:0] d, input logic rs);
    return (rs == 1'b0 && d == 8'h01) ? P_CLR : P_CMD;
  endfunction

  task automatic wait_start(output rec_t r, output bit ok);
    int t = 0;
    ok = 1'b0;
    r  = '{8'h00, 1'b0, -1};
    while (st_q.size() == 0 && t < BUDGET) begin
      @(negedge clk); #1;
      t++;
    end
    if (st_q.size() != 0) begin
      r  = st_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int c);
    int t = 0;
    while (cyc < c && t < BUDGET) begin
      @(negedge clk); #1;
      t++;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (wr_ready !== 1'b1 && t < BUDGET) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (wr_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    wr_valid   = 1'b0;
    clr_req    = 1'b0;
    force_busy = 1'b0;
    spur_done  = 1'b0;
    #1;
    n_vec++;
    if ({spi_start, spi_data, spi_rs, wr_ready, init_done} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: start=%b data=%h rs=%b ready=%b init_done=%b, want all zero",
               spi_start, spi_data, spi_rs, wr_ready, init_done);
    end
    repeat (3) @(negedge clk);
    #1;
    st_q.delete();
    rst     = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic test_init();
    logic [7:0] seq[4];
    rec_t       r;
    bit         ok;
    int         exp_c;
    int         ready_c;
    seq      = '{8'h38, 8'h0C, 8'h01, 8'h06};
    exp_c    = rel_cyc + P_PWR + 1;
    // Write requests during init must be ignored.
    wr_valid = 1'b1;
    wr_row   = 1'($urandom);
    wr_col   = 4'($urandom);
    wr_char  = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      wait_start(r, ok);
      n_vec++;
      if (!ok || r.d !== seq[k] || r.r !== 1'b0 || r.c != exp_c) begin
        n_err++;
        $display("FAIL init_byte%0d: got data=%h rs=%b cyc=%0d, want data=%h rs=0 cyc=%0d",
                 k, r.d, r.r, r.c, seq[k], exp_c);
      end
      exp_c = exp_c + DONE_OFS + gap_of(seq[k], 1'b0) + 1;
    end
    wr_valid = 1'b0;
    ready_c  = exp_c - 1;
    wait_cyc(ready_c - 1);
    n_vec++;
    if (wr_ready !== 1'b0 || init_done !== 1'b0) begin
      n_err++;
      $display("FAIL init_early_ready: ready=%b init_done=%b at cyc %0d, want 0/0", wr_ready, init_done, cyc);
    end
    wait_cyc(ready_c);
    n_vec++;
    if (wr_ready !== 1'b1 || init_done !== 1'b1 || st_q.size() != 0) begin
      n_err++;
      $display("FAIL init_complete: ready=%b init_done=%b extra_bytes=%0d at cyc %0d, want 1/1/0",
               wr_ready, init_done, st_q.size(), cyc);
    end
  endtask

  task automatic test_write(input logic row, input logic [3:0] col, input logic [7:0] ch, input int hold);
    rec_t       r;
    bit         ok;
    int         acc;
    int         exp_c;
    int         ready_c;
    logic [7:0] exp_addr;
    exp_addr = {1'b1, row, 2'b00, col};
    wait_ready(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL write_ready_wait: ready=%b, want 1 within %0d cycles", wr_ready, BUDGET);
    end
    wr_row     = row;
    wr_col     = col;
    wr_char    = ch;
    wr_valid   = 1'b1;
    force_busy = (hold > 0);
    acc        = cyc + 1;
    @(negedge clk); #1;
    // Scramble inputs after acceptance; the latched fields must be used.
    wr_valid = 1'b0;
    wr_row   = 1'($urandom);
    wr_col   = 4'($urandom);
    wr_char  = 8'($urandom);
    n_vec++;
    if (wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL write_ready_drop: ready=%b after accept, want 0", wr_ready);
    end
    if (hold > 0) begin
      wait_cyc(acc + hold);
      n_vec++;
      if (st_q.size() != 0) begin
        n_err++;
        $display("FAIL busy_withhold: %0d start pulses while busy, want 0", st_q.size());
      end
      force_busy = 1'b0;
    end
    exp_c = acc + hold + 1;
    wait_start(r, ok);
    n_vec++;
    if (!ok || r.d !== exp_addr || r.r !== 1'b0 || r.c != exp_c) begin
      n_err++;
      $display("FAIL write_addr: got data=%h rs=%b cyc=%0d, want data=%h rs=0 cyc=%0d",
               r.d, r.r, r.c, exp_addr, exp_c);
    end
    exp_c = exp_c + DONE_OFS + P_CMD + 1;
    wait_start(r, ok);
    n_vec++;
    if (!ok || r.d !== ch || r.r !== 1'b1 || r.c != exp_c) begin
      n_err++;
      $display("FAIL write_char: got data=%h rs=%b cyc=%0d, want data=%h rs=1 cyc=%0d",
               r.d, r.r, r.c, ch, exp_c);
    end
    wait_cyc(exp_c + 5);
    n_vec++;
    if (spi_data !== ch || spi_rs !== 1'b1 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL write_hold: data=%h rs=%b ready=%b mid-transfer, want %h/1/0", spi_data, spi_rs, wr_ready, ch);
    end
    ready_c = exp_c + DONE_OFS + P_CMD;
    wait_cyc(ready_c - 1);
    n_vec++;
    if (wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL write_ready_early: ready=%b at cyc %0d, want 0", wr_ready, cyc);
    end
    wait_cyc(ready_c);
    n_vec++;
    if (wr_ready !== 1'b1 || st_q.size() != 0) begin
      n_err++;
      $display("FAIL write_ready_return: ready=%b extra_bytes=%0d at cyc %0d, want 1/0", wr_ready, st_q.size(), cyc);
    end
  endtask

  task automatic test_clear(input bit with_write, input bit spur);
    rec_t r;
    bit   ok;
    int   acc;
    int   done_c;
    int   ready_c;
    wait_ready(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL clear_ready_wait: ready=%b, want 1 within %0d cycles", wr_ready, BUDGET);
    end
    clr_req  = 1'b1;
    wr_valid = with_write;
    wr_row   = 1'($urandom);
    wr_col   = 4'($urandom);
    wr_char  = 8'($urandom);
    acc      = cyc + 1;
    @(negedge clk); #1;
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    wait_start(r, ok);
    n_vec++;
    if (!ok || r.d !== 8'h01 || r.r !== 1'b0 || r.c != acc + 1) begin
      n_err++;
      $display("FAIL clear_byte: got data=%h rs=%b cyc=%0d, want data=01 rs=0 cyc=%0d", r.d, r.r, r.c, acc + 1);
    end
    done_c  = acc + 1 + DONE_OFS;
    ready_c = done_c + P_CLR;
    if (spur) begin
      wait_cyc(done_c + 1);
      spur_done = 1'b1;
      @(negedge clk); #1;
      spur_done = 1'b0;
    end
    wait_cyc(ready_c - 1);
    n_vec++;
    if (wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clear_gap_short: ready=%b at cyc %0d, want 0", wr_ready, cyc);
    end
    wait_cyc(ready_c);
    n_vec++;
    if (wr_ready !== 1'b1 || st_q.size() != 0) begin
      n_err++;
      $display("FAIL clear_ready_return: ready=%b extra_bytes=%0d at cyc %0d, want 1/0", wr_ready, st_q.size(), cyc);
    end
    if (spur) begin
      spur_done = 1'b1;
      @(negedge clk); #1;
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if (wr_ready !== 1'b1 || st_q.size() != 0) begin
        n_err++;
        $display("FAIL idle_spurious_done: ready=%b extra_bytes=%0d, want 1/0", wr_ready, st_q.size());
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) test_clear(1'($urandom_range(0, 1)), 1'b0);
      else test_write(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_reset_mid();
    rec_t r;
    bit   ok;
    wait_ready(ok);
    wr_row   = 1'b0;
    wr_col   = 4'd3;
    wr_char  = 8'h5A;
    wr_valid = 1'b1;
    @(negedge clk); #1;
    wr_valid = 1'b0;
    wait_start(r, ok);
    wait_start(r, ok);
    n_vec++;
    if (!ok || r.d !== 8'h5A || r.r !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_char: got data=%h rs=%b, want 5a/1", r.d, r.r);
    end
    wait_cyc(r.c + 3);
    test_reset();
    test_init();
  endtask

  initial begin
    #2;
    test_reset();
    test_init();
    test_write(1'b1, 4'd5, 8'h41, 0);
    test_clear(1'b1, 1'b0);
    test_write(1'b0, 4'd9, 8'h33, 6);
    test_clear(1'b0, 1'b1);
    test_random(16);
    test_write(1'b1, 4'd15, 8'hFF, 0);
    test_write(1'b0, 4'd0, 8'h00, 0);
    test_reset_mid();
    test_write(1'b0, 4'd15, 8'h7E, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/t05_1602_lcd_seq.md
Name: t05_1602_lcd_seq

Overview:
Command/data sequencer for the 1602 character LCD. It sits directly upstream of the SPI byte transmitter and drives its start/data/done handshake. After reset it runs the fixed LCD power-up and init sequence. It then accepts character-write and clear requests from the application and expands each into LCD command and data bytes, inserting the required settle delay after every byte.

Parameters:
POWERUP_CYCLES, 40000, clk cycles to wait after reset release before the first init byte
CMD_CYCLES, 400, settle gap in clk cycles after every byte except clear
CLEAR_CYCLES, 20000, settle gap in clk cycles after a clear command (0x01)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_valid  in  1  character write request
wr_ready  out  1  sequencer accepts wr_valid/clr_req this cycle
wr_row  in  1  target row (0 = top, 1 = bottom)
wr_col  in  4  target column 0..15
wr_char  in  8  character code
clr_req  in  1  clear-display request (sampled when wr_ready=1)
init_done  out  1  init sequence complete; stays high until reset
spi_start  out  1  one-cycle start pulse to the SPI transmitter
spi_data  out  8  byte to transmit; stable from spi_start until spi_done
spi_rs  out  1  LCD register select (0 = command, 1 = data); stable with spi_data
spi_busy  in  1  SPI transmitter busy
spi_done  in  1  SPI transmission-complete pulse

Behaviour:
- One clock (clk). Asynchronous active-high reset (rst). All state is reset asynchronously.
- Reset values: spi_start=0, spi_data=0x00, spi_rs=0, wr_ready=0, init_done=0, state=PWR_WAIT, delay counter loaded with POWERUP_CYCLES.
- States: PWR_WAIT, ISSUE, XFER, GAP, IDLE. A phase register selects the byte source: INIT0..INIT3, ADDR, CHAR, CLEAR.
- PWR_WAIT: counts down for exactly POWERUP_CYCLES cycles after reset deasserts, then goes to ISSUE with phase=INIT0.
- Init bytes, all with rs=0:
  - INIT0 = 0x38 (function set)
  - INIT1 = 0x0C (display on)
  - INIT2 = 0x01 (clear)
  - INIT3 = 0x06 (entry mode)
- ISSUE:
  - Drives spi_data/spi_rs for the current phase.
  - If spi_busy=0, pulses spi_start for exactly one cycle and moves to XFER.
  - If spi_busy=1, holds in ISSUE with no pulse.
- XFER: holds spi_data/spi_rs. On spi_done=1, loads the gap counter and moves to GAP.
  - Gap is CLEAR_CYCLES if the byte sent was rs=0 with data 0x01; otherwise CMD_CYCLES.
- GAP: stays for exactly the loaded number of cycles. Next state depends on phase:
  - INITn with n<3: ISSUE with phase INITn+1.
  - INIT3: set init_done and go to IDLE.
  - ADDR: ISSUE with phase CHAR.
  - CHAR or CLEAR: IDLE.
- IDLE:
  - wr_ready=1 only in IDLE with init_done=1; wr_ready=0 in every other state.
  - Clear request: clr_req=1 → phase CLEAR (byte 0x01, rs=0), go to ISSUE.
  - Write request: wr_valid=1 (and clr_req=0) → latch row/col/char, phase ADDR, go to ISSUE.
    - ADDR byte = 0x80 | (wr_row ? 0x40 : 0x00) | wr_col, rs=0.
    - CHAR byte = latched char, rs=1.
  - Simultaneous clr_req and wr_valid: clear wins; the write is not accepted and must be re-presented.
- Requests present while wr_ready=0 are ignored; nothing is queued.
- spi_done outside XFER is ignored.
- Latched write fields are unaffected by input changes after acceptance.
- Delay counter width is $clog2(max(POWERUP_CYCLES, CMD_CYCLES, CLEAR_CYCLES)+1). A gap value of 0 passes through GAP in one cycle.
- Reset asserted mid-transfer: the block returns to PWR_WAIT and repeats the full init sequence. spi_start is deasserted immediately.
- Latency, write accepted to first spi_start: 2 cycles (IDLE→ISSUE, then ISSUE asserts start), provided spi_busy=0.

Test Plan:
Bench overrides POWERUP_CYCLES=8, CMD_CYCLES=2, CLEAR_CYCLES=5. The SPI model raises spi_busy the cycle after start and pulses spi_done 12 cycles after start.
- Reset release → first spi_start 9 cycles later with spi_data=0x38/rs=0; then 0x0C, 0x01, 0x06 in order; init_done=1 and wr_ready=1 after the last gap; gap after 0x01 is 5 cycles, the others 2.
- wr_valid with row=1, col=5, char=0x41 → bytes 0x C5/rs=0 then 0x41/rs=1; wr_ready low throughout; high again 2 cycles after the second spi_done.
- clr_req and wr_valid asserted the same cycle → only 0x01/rs=0 is sent with a 5-cycle gap; the write is not sent; wr_ready returns high.
- spi_busy held high for 6 cycles while in ISSUE → spi_start is withheld until busy falls, then pulses exactly once.
- Spurious spi_done in IDLE and GAP → no state change; wr_valid during init → ignored, no extra bytes sent.
- rst asserted 3 cycles into a CHAR transfer → outputs at reset values immediately; after release the full init sequence replays starting with 0x38.
